// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the serial pattern detector.
// Optional match counter is enabled by SEQ_DET_MATCH_CNT_EN.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter; clear has priority over increment.
// Only instantiated when SEQ_DET_MATCH_CNT_EN is defined.
module seq_det_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Loadable serial pattern detector with overlap control.
// Match counter present only with SEQ_DET_MATCH_CNT_EN defined.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             detected,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             det_q, det_d;
  logic             armed_q;

  logic             accept;
  logic             match;
  logic [PAT_W-1:0] win;

  assign win    = {hist_q, din};
  assign accept = din_valid & ~load & (state_q != IDLE);
  assign match  = accept & (state_q == ARMED) & (win == pat_q);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    det_d   = 1'b0;
    unique case (1'b1)
      load: begin
        pat_d   = pat_in;
        hist_d  = '0;
        fill_d  = '0;
        state_d = FILL;
      end
      accept: begin
        det_d = match;
        // non-overlapping mode restarts collection after a hit
        if (match && !overlap) begin
          hist_d  = '0;
          fill_d  = '0;
          state_d = FILL;
        end else begin
          hist_d = win[PAT_W-2:0];
          if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
          end
          if (fill_d == FILL_MAX) begin
            state_d = ARMED;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      det_q   <= det_d;
      armed_q <= (state_d == ARMED);
    end
  end

  assign detected = det_q;
  assign armed    = armed_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  seq_det_match_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (match),
    .clr   (cnt_clr),
    .count (match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: vector tables, corner sequences, random vs model.
// Count expectations follow SEQ_DET_MATCH_CNT_EN.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       din, din_valid, load, overlap, cnt_clr;
  logic [3:0] pat_in;
  logic       det, arm, det2, arm2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  bit loaded;
  int m_pat, m_hv, m_nb;
  int e_det, e_cnt, e_cnt2;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .load(load), .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr),
    .detected(det), .armed(arm), .match_cnt(cnt)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .load(load), .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr),
    .detected(det2), .armed(arm2), .match_cnt(cnt2)
  );

  typedef struct {
    bit       d;
    bit       v;
    bit       ld;
    bit [3:0] p;
    bit       ov;
    bit       clr;
    bit       x_det;
    bit       x_arm;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    loaded = 0;
    m_pat = 0; m_hv = 0; m_nb = 0;
    e_det = 0; e_cnt = 0; e_cnt2 = 0;
  endfunction

  function automatic void model_step(bit d, bit v, bit ld, int p,
                                     bit ov, bit clr);
    bit m;
    int w;
    m = 0;
    e_det = 0;
    if (ld) begin
      m_pat = p; m_hv = 0; m_nb = 0; loaded = 1;
    end else if (v && loaded) begin
      w = ((m_hv << 1) | d) & 15;
      m = (m_nb >= 3) && (w == m_pat);
      e_det = m;
      if (m && !ov) begin
        m_hv = 0; m_nb = 0;
      end else begin
        m_hv = w & 7;
        m_nb++;
      end
    end
`ifdef SEQ_DET_MATCH_CNT_EN
    if (clr) begin
      e_cnt = 0; e_cnt2 = 0;
    end else if (m) begin
      if (e_cnt < 255) e_cnt++;
      if (e_cnt2 < 3) e_cnt2++;
    end
`endif
  endfunction

  function automatic int e_arm();
    return (loaded && m_nb >= 3) ? 1 : 0;
  endfunction

  // drive one cycle from just after an edge, then check after the next
  task automatic step(bit d, bit v, bit ld, bit [3:0] p, bit ov, bit clr);
    din = d; din_valid = v; load = ld; pat_in = p;
    overlap = ov; cnt_clr = clr;
    @(posedge clk);
    model_step(d, v, ld, int'(p), ov, clr);
    #1;
    chk("detected", int'(det), e_det);
    chk("armed", int'(arm), e_arm());
    chk("match_cnt", int'(cnt), e_cnt);
    chk("match_cnt_w2", int'(cnt2), e_cnt2);
  endtask

  task automatic bits4(bit [3:0] b, bit ov);
    for (int i = 3; i >= 0; i--) step(b[i], 1'b1, 1'b0, 4'd0, ov, 1'b0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_detected", int'(det), 0);
    chk("rst_armed", int'(arm), 0);
    chk("rst_cnt", int'(cnt), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    din = 0; din_valid = 0; load = 0; pat_in = 0; overlap = 0; cnt_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_detected", int'(det), 0);
    chk("rst_armed", int'(arm), 0);
    chk("rst_cnt", int'(cnt), 0);
    reset_n = 1'b1;

    // no pattern loaded: IDLE ignores data
    bits4(4'b1010, 1'b1);

    // overlapping then non-overlapping on 10101010
    tbl.push_back('{0,0,1,4'b1010,1,0, 0,0});
    tbl.push_back('{1,1,0,0,1,0, 0,0});
    tbl.push_back('{0,1,0,0,1,0, 0,0});
    tbl.push_back('{1,1,0,0,1,0, 0,1});
    tbl.push_back('{0,1,0,0,1,0, 1,1});
    tbl.push_back('{1,1,0,0,1,0, 0,1});
    tbl.push_back('{0,1,0,0,1,0, 1,1});
    tbl.push_back('{1,1,0,0,1,0, 0,1});
    tbl.push_back('{0,1,0,0,1,0, 1,1});
    tbl.push_back('{0,0,1,4'b1010,0,0, 0,0});
    tbl.push_back('{1,1,0,0,0,0, 0,0});
    tbl.push_back('{0,1,0,0,0,0, 0,0});
    tbl.push_back('{1,1,0,0,0,0, 0,1});
    tbl.push_back('{0,1,0,0,0,0, 1,0});
    tbl.push_back('{1,1,0,0,0,0, 0,0});
    tbl.push_back('{0,1,0,0,0,0, 0,0});
    tbl.push_back('{1,1,0,0,0,0, 0,1});
    tbl.push_back('{0,1,0,0,0,0, 1,0});
    tbl.push_back('{0,0,0,0,0,0, 0,0});
    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].v, tbl[i].ld, tbl[i].p, tbl[i].ov, tbl[i].clr);
      chk($sformatf("tbl%0d_det", i), int'(det), int'(tbl[i].x_det));
      chk($sformatf("tbl%0d_arm", i), int'(arm), int'(tbl[i].x_arm));
    end
`ifdef SEQ_DET_MATCH_CNT_EN
    chk("cnt_after_5", int'(cnt), 5);
    chk("cnt_w2_sat", int'(cnt2), 3);
`else
    chk("cnt_off", int'(cnt), 0);
`endif

    // load mid-stream with a coincident valid bit
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'b1010, 1'b1, 1'b0);
    chk("load_disarm", int'(arm), 0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("load_no_early", int'(det), 0);
    bits4(4'b1010, 1'b1);
    chk("load_new4", int'(det), 1);

    // reset after three bits discards history and pattern
    step(1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("pre_rst_armed", int'(arm), 1);
    pulse_reset();
    bits4(4'b1010, 1'b1);
    chk("post_rst_nodet", int'(det), 0);

    // clear wins over a coincident match
    step(1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b0);
    bits4(4'b1010, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("clr_match_det", int'(det), 1);
    chk("clr_match_cnt", int'(cnt), 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit ld, v, clr;
      ld  = ($urandom_range(99) < 4);
      v   = ($urandom_range(99) < 75);
      clr = ($urandom_range(99) < 3);
      step(1'($urandom), v, ld, 4'($urandom), 1'($urandom), clr);
      if ($urandom_range(999) == 0) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- PAT_W, 4, pattern length in bits (2..16).
- CNT_W, 8, match counter width (1..16).
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, input, 1, sole clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- din, input, 1, serial data bit.
- din_valid, input, 1, din is sampled this cycle.
- load, input, 1, load new pattern.
- pat_in, input, PAT_W, pattern; first-received bit at MSB.
- overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
- cnt_clr, input, 1, synchronous clear of match_cnt.
- detected, output, 1, registered one-cycle match pulse.
- armed, output, 1, state == ARMED.
- match_cnt, output, CNT_W, saturating match count.

Function
REQ-003 State machine SHALL have three states:
- IDLE: no pattern loaded.
- FILL: fewer than PAT_W-1 history bits held.
- ARMED: PAT_W-1 history bits held.
REQ-004 Internal registers SHALL be:
- pattern (PAT_W bits).
- hist (PAT_W-1 bits; newest bit at LSB).
- fill counter (saturates at PAT_W-1).
REQ-005 A bit is accepted on a rising edge with din_valid=1, load=0 and state != IDLE; IDLE ignores din_valid.
REQ-006 On an accepted bit, hist SHALL shift left with din entering the LSB, and fill SHALL increment, saturating at PAT_W-1.
REQ-007 Match SHALL be an accepted bit with state == ARMED and {hist, din} == pattern.
REQ-008 On a match, detected SHALL be 1 in the cycle after the matching bit and 0 otherwise; it is never high two cycles running from a single match.
REQ-009 On a match with overlap=1, hist shifts normally and state stays ARMED.
REQ-010 On a match with overlap=0, hist and fill SHALL clear to 0 and state SHALL go to FILL.
REQ-011 State SHALL go FILL -> ARMED on the accepted bit that brings fill to PAT_W-1.
REQ-012 load=1 SHALL, in any state:
- set pattern <= pat_in and clear hist and fill;
- set state <= FILL;
- suppress detection that cycle.
A din_valid bit in the same cycle is discarded.
REQ-013 overlap is sampled per accepted bit and may change at any time; the new value takes effect on the next match.
REQ-014 Bits with din_valid=0 SHALL leave hist, fill, state and detected unchanged, except that detected drops to 0.

Reset
REQ-015 reset_n=0 SHALL asynchronously force the following; release is synchronous to clk:
- state = IDLE;
- pattern, hist and fill = 0;
- detected = 0, armed = 0, match_cnt = 0.
REQ-016 Reset asserted mid-sequence SHALL discard partial history; after release, detection requires a new load.

Configuration
REQ-017 With macro SEQ_DET_MATCH_CNT_EN defined, match_cnt SHALL behave as follows:
- increments by 1 on each match;
- saturates at 2^CNT_W-1;
- cnt_clr sets it to 0;
- cnt_clr wins over a simultaneous match (result 0).
REQ-018 Without SEQ_DET_MATCH_CNT_EN, match_cnt SHALL be tied to 0, cnt_clr ignored, and no counter flops generated.

Structure
REQ-019 Package seq_det_pkg SHALL hold:
- the state enum (IDLE, FILL, ARMED);
- default PAT_W and CNT_W constants.
REQ-020 The saturating counter SHALL be sub-module seq_det_match_cnt (parameter CNT_W; inputs inc, clr; output count), instantiated only under SEQ_DET_MATCH_CNT_EN.

Verification (PAT_W=4, CNT_W=8, macro defined unless stated)
REQ-021 Reset release, then din_valid=1 bits 1,0,1,0 without load -> detected stays 0, armed=0, match_cnt=0.
REQ-022 load pat_in=1010, overlap=1, bits 1,0,1,0,1,0,1,0 -> detected pulses after bits 4, 6 and 8; match_cnt=3.
REQ-023 Same stream with overlap=0 -> detected pulses after bits 4 and 8 only; match_cnt=2.
REQ-024 load pat_in=1010 mid-stream with din_valid=1 in the same cycle -> that bit is discarded, armed=0 next cycle, detection needs 4 new bits; also reset_n pulsed low after 3 bits -> state IDLE immediately, no detect.
REQ-025 CNT_W=2, 5 matches -> match_cnt saturates at 3; cnt_clr coincident with a match -> match_cnt=0; build without the macro -> match_cnt=0 throughout.
